bram_burst_controller: RTL and testbench
========================================

Name: bram_burst_controller

Overview:
- Parametrised successor to the single-shot button-driven BRAM read sequencer.
- Runs a configurable-length burst of sequential BRAM reads or writes from a persistent, wrapping address pointer.
- Reads are collected through a configurable read-latency pipeline; writes consume a streaming data input.
- Sits between user control logic (buttons/FSMs) and a single-port block RAM.

Parameters:
ADDR_W, 4, address width; pointer wraps modulo 2^ADDR_W
DATA_W, 8, BRAM data width
RD_LAT, 1, BRAM read latency in cycles (1..4): douta is valid RD_LAT cycles after the address cycle

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  start a burst; sampled only in IDLE
mode  in  1  0 = read burst, 1 = write burst; latched with start
len  in  ADDR_W  burst length minus 1; latched with start
load_addr  in  1  load pointer from base_addr; honoured only in IDLE
base_addr  in  ADDR_W  pointer load value
abort  in  1  terminate active burst
wr_data  in  DATA_W  write data source
wr_ack  out  1  wr_data consumed this cycle
ena  out  1  BRAM enable
wea  out  1  BRAM write enable
addra  out  ADDR_W  BRAM address
dina  out  DATA_W  BRAM write data
douta  in  DATA_W  BRAM read data
rd_data  out  DATA_W  registered read data
rd_valid  out  1  rd_data valid, one pulse per word
busy  out  1  burst in progress (RUN, DRAIN or FIN)
done  out  1  one-cycle completion pulse
aborted  out  1  one-cycle abort pulse

Behaviour:
- Reset (async, any state): state=IDLE; ptr=0; all outputs 0; read pipeline cleared.
- States:
  - IDLE: load_addr=1 -> ptr<=base_addr. start=1 -> latch mode, rem<=len, go RUN. If load_addr and start coincide, the burst begins at base_addr.
  - RUN: every cycle ena=1, addra=ptr, wea=mode. ptr<=ptr+1 mod 2^ADDR_W; rem<=rem-1. When rem==0 this cycle: write -> FIN; read -> DRAIN. Total accesses = len+1.
  - DRAIN: hold until the last read's rd_valid has been issued, then -> FIN. ena=0.
  - FIN: done=1 for exactly one cycle, -> IDLE.
- Outputs are combinational from state/regs (ena, wea, addra, dina, wr_ack); rd_data, rd_valid, done and aborted are registered.
- Write mode: dina=wr_data and wr_ack=1 in every RUN cycle. The source must present the next word the cycle after wr_ack. No stall support.
- Read mode: rd_valid/rd_data appear RD_LAT+1 cycles after the corresponding RUN cycle (BRAM latency plus one output register). rd_data=douta sampled at issue+RD_LAT. Words arrive in address order, one per cycle, contiguous.
- First RUN cycle follows the start cycle (1-cycle start latency). busy rises with RUN and falls when returning to IDLE.
- done timing:
  - Read burst: done is asserted the cycle after the last rd_valid.
  - Write burst: done is asserted the cycle after the last write.
- ptr persists across bursts. The next burst without load_addr continues at last+1. Wrap 2^ADDR_W-1 -> 0 is silent and legal within a burst.
- start, load_addr and len are ignored while busy.
- abort in RUN/DRAIN: next state IDLE; ena/wea deassert next cycle; aborted=1 for one cycle; done not pulsed.
  - Pending pipeline reads are flushed; no rd_valid after the abort cycle.
  - ptr retains its value at abort (next unissued address).
  - abort in IDLE/FIN has no effect.
- wea is never 1 outside RUN with mode=1. ena is never 1 outside RUN.
- No X on any output after reset deasserts.

Test Plan:
- Reset, load_addr base_addr=3, start mode=0 len=3, RD_LAT=1 -> addra 3,4,5,6 on 4 consecutive cycles with wea=0; rd_valid 4 cycles starting 2 cycles after first issue; done 1 cycle after last rd_valid; busy 0 afterwards.
- Write burst base_addr=14 len=3 with wr_data 0xA0..0xA3 -> addra 14,15,0,1 with wea=1, dina matches, 4 wr_ack pulses, done next cycle, ptr=2. Follow with read len=0 and no load -> addra=2.
- Write then read back len=15 over a behavioural BRAM model with RD_LAT=2 -> 16 rd_valid words equal to the written data, in order.
- start, load_addr and different len asserted during RUN -> ignored; burst length and addresses unchanged.
- abort in the second RUN cycle of a read len=7 -> ena=0 next cycle, aborted pulse, no further rd_valid, no done, ptr=base+2.
- Async reset asserted mid-DRAIN -> all outputs 0 immediately, ptr=0, IDLE; new burst after release starts at address 0.

Source files
------------

// File: rtl/bram_burst_controller.sv
// -----------------------------------------------------------------------------
// bram_burst_controller
//
// Runs bursts of sequential reads or writes against a single-port block RAM
// from a persistent address pointer that wraps modulo 2**ADDR_W. A burst is
// len+1 accesses long, one access per cycle, starting the cycle after start.
//
// Read bursts: data returns through the BRAM's RD_LAT-cycle latency and one
// output register, so rd_valid/rd_data appear RD_LAT+1 cycles after the
// corresponding address cycle, in address order, contiguous.
// Write bursts: wr_data is passed straight to dina and acknowledged with
// wr_ack every access cycle; the source must present a new word each cycle.
//
// Parameters
//   ADDR_W  address width (pointer wraps modulo 2**ADDR_W)
//   DATA_W  BRAM data width
//   RD_LAT  BRAM read latency in cycles (1..4)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      start a burst (sampled only when idle)
//   mode       0 = read burst, 1 = write burst (latched with start)
//   len        burst length minus 1 (latched with start)
//   load_addr  load pointer from base_addr (honoured only when idle)
//   base_addr  pointer load value
//   abort      terminate an active burst (RUN or DRAIN)
//   wr_data    write data source
//   wr_ack     wr_data consumed this cycle
//   ena        BRAM enable
//   wea        BRAM write enable
//   addra      BRAM address
//   dina       BRAM write data
//   douta      BRAM read data
//   rd_data    registered read data
//   rd_valid   rd_data valid, one pulse per word
//   busy       burst in progress (RUN, DRAIN or FIN)
//   done       one-cycle completion pulse
//   aborted    one-cycle abort pulse
// -----------------------------------------------------------------------------
module bram_burst_controller #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] len,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;       // next address to issue; survives bursts
  logic [ADDR_W-1:0] rem_q;       // accesses left after the current one
  logic              mode_q;      // latched burst direction
  logic              done_q;
  logic              aborted_q;

  // One bit per read still travelling through the BRAM latency. Bit 0 is set
  // the cycle after the address is issued; bit RD_LAT-1 marks the cycle in
  // which douta holds that read's data.
  logic [RD_LAT-1:0] pipe_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic in_run;
  logic in_drain;
  logic wr_cycle;
  logic rd_issue;
  logic flush;
  logic pipe_empty;

  assign in_run     = (state_q == S_RUN);
  assign in_drain   = (state_q == S_DRAIN);
  assign wr_cycle   = in_run &  mode_q;
  // A read issued in the abort cycle still reaches the BRAM but its data is
  // discarded, so it never enters the pipeline.
  assign rd_issue   = in_run & ~mode_q & ~abort;
  assign flush      = abort & (in_run | in_drain);
  assign pipe_empty = (pipe_q == '0);

  // BRAM-side outputs are decoded straight from state so the access happens
  // in the same cycle the FSM is in RUN; outside RUN everything is driven 0.
  assign ena    = in_run;
  assign wea    = wr_cycle;
  assign addra  = in_run   ? ptr_q   : '0;
  assign dina   = wr_cycle ? wr_data : '0;
  assign wr_ack = wr_cycle;

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // ---------------------------------------------------------------------------
  // Burst sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side below sees the pre-edge value; the pulse outputs get a
      // default here and are overridden by the single transition that sets them.
      done_q    <= 1'b0;
      aborted_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // Load and start may coincide: the burst then begins at base_addr.
          if (load_addr) begin
            ptr_q <= base_addr;
          end
          if (start) begin
            mode_q  <= mode;
            rem_q   <= len;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          // The access of the current cycle is issued even when aborting, so
          // the pointer always advances past it.
          ptr_q <= ptr_q + ADDR_W'(1);
          rem_q <= rem_q - ADDR_W'(1);
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= S_IDLE;
          end else if (rem_q == '0) begin
            if (mode_q) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // Once the pipeline is empty the last rd_valid is on the output this
          // cycle, so FIN (and its done pulse) lands on the following cycle.
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= S_IDLE;
          end else if (pipe_empty) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path: latency tracker plus one output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (flush) begin
      // Anything still in flight belongs to the aborted burst.
      pipe_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      pipe_q[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      rd_valid_q <= pipe_q[RD_LAT-1];
      if (pipe_q[RD_LAT-1]) begin
        rd_data_q <= douta;
      end
    end
  end

`ifndef SYNTHESIS
  // Write enable only ever qualifies an enabled access.
  a_wea_needs_ena : assert property (@(posedge clk) disable iff (reset)
    wea |-> ena);
  // No BRAM access is made while the controller reports idle.
  a_ena_needs_busy : assert property (@(posedge clk) disable iff (reset)
    ena |-> busy);
  // Completion and abort are mutually exclusive.
  a_done_xor_abort : assert property (@(posedge clk) disable iff (reset)
    !(done && aborted));
`endif

endmodule

// File: tb/tb_bram_burst_controller.sv
// -----------------------------------------------------------------------------
// tb_bram_burst_controller
//
// Two controller instances (RD_LAT = 1 and RD_LAT = 2) share every input and
// each drive their own behavioural BRAM. Expected outputs come from a
// transaction-level model: a burst is described by start cycle, base, length,
// mode and abort cycle, and each cycle's outputs are derived from the timing
// rules (access k at cycle k+1, read word j valid at cycle j+RD_LAT+2, done
// the cycle after the last write or last rd_valid).
// -----------------------------------------------------------------------------
module tb_bram_burst_controller;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          wr_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          aborted;
  } out_t;

  typedef struct {
    bit m;       int len;  bit ld;   int base; int abort_k; bit noise;
    bit seqw;    int wbase;
    int first;   int acc;  int rdv1; int rdv2; int wack;    int dn;  int abt;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_s, mode_s, load_s, abort_s;
  logic [AW-1:0] len_s, base_s;
  logic [DW-1:0] wdata_s;

  logic          ena_s      [2];
  logic          wea_s      [2];
  logic [AW-1:0] addra_s    [2];
  logic [DW-1:0] dina_s     [2];
  logic          wr_ack_s   [2];
  logic [DW-1:0] rd_data_s  [2];
  logic          rd_valid_s [2];
  logic          busy_s     [2];
  logic          done_s     [2];
  logic          aborted_s  [2];
  logic [DW-1:0] douta0, douta1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_ptr;
  int obs_first [2];
  int obs_acc   [2];
  int obs_rdv   [2];
  int obs_wack  [2];
  int obs_dn    [2];
  int obs_abt   [2];

  always #5 clk = ~clk;

  bram_burst_controller #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_s), .mode(mode_s), .len(len_s),
    .load_addr(load_s), .base_addr(base_s), .abort(abort_s), .wr_data(wdata_s),
    .wr_ack(wr_ack_s[0]), .ena(ena_s[0]), .wea(wea_s[0]), .addra(addra_s[0]),
    .dina(dina_s[0]), .douta(douta0), .rd_data(rd_data_s[0]),
    .rd_valid(rd_valid_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .aborted(aborted_s[0])
  );

  bram_burst_controller #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_s), .mode(mode_s), .len(len_s),
    .load_addr(load_s), .base_addr(base_s), .abort(abort_s), .wr_data(wdata_s),
    .wr_ack(wr_ack_s[1]), .ena(ena_s[1]), .wea(wea_s[1]), .addra(addra_s[1]),
    .dina(dina_s[1]), .douta(douta1), .rd_data(rd_data_s[1]),
    .rd_valid(rd_valid_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .aborted(aborted_s[1])
  );

  // Behavioural single-port BRAMs, latency 1 and 2.
  logic [DW-1:0] mem0 [DEPTH] = '{default: '0};
  logic [DW-1:0] mem1 [DEPTH] = '{default: '0};
  logic [DW-1:0] q0 = '0, q1a = '0, q1b = '0;

  always @(posedge clk) begin
    if (ena_s[0] && wea_s[0]) mem0[addra_s[0]] <= dina_s[0];
    q0 <= mem0[addra_s[0]];
    if (ena_s[1] && wea_s[1]) mem1[addra_s[1]] <= dina_s[1];
    q1a <= mem1[addra_s[1]];
    q1b <= q1a;
  end
  assign douta0 = q0;
  assign douta1 = q1b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t get_out(input int i);
    out_t o;
    o.ena = ena_s[i];         o.wea = wea_s[i];
    o.addra = addra_s[i];     o.dina = dina_s[i];
    o.wr_ack = wr_ack_s[i];   o.rd_valid = rd_valid_s[i];
    o.rd_data = rd_data_s[i]; o.busy = busy_s[i];
    o.done = done_s[i];       o.aborted = aborted_s[i];
    return o;
  endfunction

  // Cycle (counted from the start cycle = 0) carrying the done pulse.
  function automatic int fin_cycle(input int lat, input bit m, input int len);
    return m ? len + 2 : len + lat + 3;
  endfunction

  // Abort only takes effect while the burst is in its access or drain phase.
  function automatic int eff_abort(input int lat, input bit m, input int len, input int abort_k);
    if (abort_k >= 1 && abort_k < fin_cycle(lat, m, len)) return abort_k;
    return -1;
  endfunction

  function automatic out_t expect_at(input int lat, input int k, input bit m, input int len,
                                     input int p0, input int abort_k, input logic [DW-1:0] wd);
    out_t e;
    int   fin, ab, last_busy, j;
    bit   alive;
    e         = '0;
    fin       = fin_cycle(lat, m, len);
    ab        = eff_abort(lat, m, len, abort_k);
    last_busy = (ab >= 0) ? ab : fin;
    alive     = (ab < 0) || (k <= ab);
    e.busy    = (k >= 1) && (k <= last_busy);
    if (k >= 1 && k <= len + 1 && alive) begin
      e.ena    = 1'b1;
      e.wea    = m;
      e.addra  = AW'((p0 + k - 1) % DEPTH);
      e.wr_ack = m;
      e.dina   = m ? wd : '0;
    end
    e.done    = (ab < 0) && (k == fin);
    e.aborted = (ab >= 0) && (k == ab + 1);
    j = k - lat - 2;
    if (!m && j >= 0 && j <= len && alive) begin
      e.rd_valid = 1'b1;
      e.rd_data  = ref_mem[(p0 + j) % DEPTH];
    end
    return e;
  endfunction

  // Runs one burst from the start cycle until both instances are idle again,
  // comparing every cycle with the model. Entered and left at posedge+1.
  task automatic run_burst(input bit m, input int len, input bit ld, input int base,
                           input int abort_k, input bit noise, input bit seqw,
                           input int wbase, input string tag);
    int            p0, kmax, lb, ab, executed;
    logic [DW-1:0] wd;
    logic [DW-1:0] new_mem [DEPTH];
    out_t          a, e;
    p0   = ld ? base : ref_ptr;
    kmax = 0;
    for (int i = 0; i < 2; i++) begin
      ab = eff_abort(i + 1, m, len, abort_k);
      lb = (ab >= 0) ? ab : fin_cycle(i + 1, m, len);
      if (lb + 2 > kmax) kmax = lb + 2;
      obs_first[i] = -1; obs_acc[i] = 0; obs_rdv[i] = 0;
      obs_wack[i]  = 0;  obs_dn[i]  = 0; obs_abt[i] = 0;
    end
    new_mem = ref_mem;
    for (int k = 0; k <= kmax; k++) begin
      start_s = 1'b0; load_s = 1'b0; mode_s = 1'b0; len_s = '0; base_s = '0;
      if (k == 0) begin
        start_s = 1'b1; mode_s = m; len_s = AW'(len); load_s = ld; base_s = AW'(base);
      end else if (noise && k <= len + 1 && (abort_k < 1 || k <= abort_k)) begin
        start_s = 1'b1; load_s = 1'b1;
        mode_s  = 1'($urandom_range(0, 1));
        len_s   = AW'($urandom_range(0, DEPTH - 1));
        base_s  = AW'($urandom_range(0, DEPTH - 1));
      end
      abort_s = (k == abort_k);
      wd      = (seqw && k >= 1 && k <= len + 1) ? DW'(wbase + k - 1) : DW'($urandom);
      wdata_s = wd;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        a = get_out(i);
        e = expect_at(i + 1, k, m, len, p0, abort_k, wd);
        if (!e.rd_valid) begin
          a.rd_data = '0;
          e.rd_data = '0;
        end
        check($sformatf("%s lat%0d cyc%0d", tag, i + 1, k), 64'(a), 64'(e));
        if (a.ena === 1'b1) begin
          obs_acc[i]++;
          if (obs_first[i] < 0) obs_first[i] = int'(a.addra);
        end
        if (a.rd_valid === 1'b1) obs_rdv[i]++;
        if (a.wr_ack === 1'b1)   obs_wack[i]++;
        if (a.done === 1'b1)     obs_dn[i]++;
        if (a.aborted === 1'b1)  obs_abt[i]++;
        if (i == 0 && e.ena && e.wea) new_mem[e.addra] = wd;
      end
      @(posedge clk); #1;
    end
    start_s = 1'b0; load_s = 1'b0; abort_s = 1'b0;
    ab       = eff_abort(1, m, len, abort_k);
    executed = (ab >= 1 && ab <= len + 1) ? ab : len + 1;
    ref_ptr  = (p0 + executed) % DEPTH;
    ref_mem  = new_mem;
  endtask

  vec_t vecs [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,  3, 1,  3, -1, 0, 0, 0,     3,  4,  4,  4,  0, 1, 0};
    vecs[1]  = '{1,  3, 1, 14, -1, 0, 1, 'hA0, 14,  4,  0,  0,  4, 1, 0};
    vecs[2]  = '{0,  0, 0,  0, -1, 0, 0, 0,     2,  1,  1,  1,  0, 1, 0};
    vecs[3]  = '{1, 15, 1,  0, -1, 0, 1, 'h50,  0, 16,  0,  0, 16, 1, 0};
    vecs[4]  = '{0, 15, 0,  0, -1, 0, 0, 0,     0, 16, 16, 16,  0, 1, 0};
    vecs[5]  = '{0,  4, 1,  5, -1, 1, 0, 0,     5,  5,  5,  5,  0, 1, 0};
    vecs[6]  = '{0,  7, 1,  8,  2, 0, 0, 0,     8,  2,  0,  0,  0, 0, 1};
    vecs[7]  = '{0,  1, 0,  0, -1, 0, 0, 0,    10,  2,  2,  2,  0, 1, 0};
    vecs[8]  = '{1,  2, 1, 15,  3, 0, 1, 'hC0, 15,  3,  0,  0,  3, 0, 1};
    vecs[9]  = '{0,  2, 1, 15, -1, 0, 0, 0,    15,  3,  3,  3,  0, 1, 0};
    vecs[10] = '{0,  1, 1,  0,  3, 0, 0, 0,     0,  2,  1,  0,  0, 0, 1};
    vecs[11] = '{1,  0, 0,  0,  2, 0, 1, 'h11,  2,  1,  0,  0,  1, 1, 0};
    vecs[12] = '{1,  5, 0,  0, -1, 1, 1, 'h30,  3,  6,  0,  0,  6, 1, 0};

    ref_mem = '{default: '0};
    ref_ptr = 0;
    reset = 1'b1;
    start_s = 1'b0; mode_s = 1'b0; load_s = 1'b0; abort_s = 1'b0;
    len_s = '0; base_s = '0; wdata_s = '0;

    // Outputs during and right after reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("in_reset lat%0d", i + 1), 64'(get_out(i)), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("post_reset lat%0d", i + 1), 64'(get_out(i)), 64'd0);
    @(posedge clk); #1;

    // Directed bursts with hand-derived outcome counts.
    for (int v = 0; v < 13; v++) begin
      run_burst(vecs[v].m, vecs[v].len, vecs[v].ld, vecs[v].base, vecs[v].abort_k,
                vecs[v].noise, vecs[v].seqw, vecs[v].wbase, $sformatf("vec%0d", v));
      for (int i = 0; i < 2; i++) begin
        check($sformatf("vec%0d lat%0d first_addr", v, i + 1), 64'(obs_first[i]), 64'(vecs[v].first));
        check($sformatf("vec%0d lat%0d accesses", v, i + 1),   64'(obs_acc[i]),   64'(vecs[v].acc));
        check($sformatf("vec%0d lat%0d rd_valids", v, i + 1),  64'(obs_rdv[i]),
              64'(i == 0 ? vecs[v].rdv1 : vecs[v].rdv2));
        check($sformatf("vec%0d lat%0d wr_acks", v, i + 1),    64'(obs_wack[i]),  64'(vecs[v].wack));
        check($sformatf("vec%0d lat%0d dones", v, i + 1),      64'(obs_dn[i]),    64'(vecs[v].dn));
        check($sformatf("vec%0d lat%0d aborts", v, i + 1),     64'(obs_abt[i]),   64'(vecs[v].abt));
      end
    end

    // Asynchronous reset in the middle of DRAIN (read from 4, len 2).
    start_s = 1'b1; load_s = 1'b1; base_s = 4'd4; mode_s = 1'b0; len_s = 4'd2;
    @(posedge clk); #1;
    start_s = 1'b0; load_s = 1'b0; base_s = '0; len_s = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("pre_async_reset lat%0d busy", i + 1), 64'(busy_s[i]), 64'd1);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("async_reset lat%0d", i + 1), 64'(get_out(i)), 64'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    ref_ptr = 0;
    run_burst(1'b0, 0, 1'b0, 0, -1, 1'b0, 1'b0, 0, "after_reset");
    for (int i = 0; i < 2; i++) begin
      check($sformatf("after_reset lat%0d first_addr", i + 1), 64'(obs_first[i]), 64'd0);
      check($sformatf("after_reset lat%0d rd_valids", i + 1),  64'(obs_rdv[i]),   64'd1);
    end

    // Randomised bursts against the model.
    for (int r = 0; r < 40; r++) begin
      int rlen, rab;
      rlen = $urandom_range(0, DEPTH - 1);
      rab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rlen + 5) : -1;
      run_burst(1'($urandom_range(0, 1)), rlen, 1'($urandom_range(0, 1)),
                $urandom_range(0, DEPTH - 1), rab, ($urandom_range(0, 2) == 0),
                1'b0, 0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
